// File: rtl/burst_memory_pkg.sv
// Shared types and helpers for the burst_memory block: FSM state encoding,
// burst-length decode and the width of the beat counter.
package burst_memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } state_t;

  // Wide enough to count the remaining beats of the longest (8-beat) burst.
  localparam int BURST_CNT_W = 3;

  function automatic logic [3:0] blen_to_beats(input logic [1:0] blen);
    logic [3:0] beats;
    case (blen)
      2'b00:   beats = 4'd1;
      2'b01:   beats = 4'd2;
      2'b10:   beats = 4'd4;
      default: beats = 4'd8;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/burst_memory_mem_array.sv
// Single-port DEPTH x DATA_W storage with byte-enable writes and a registered read port.
// With MEM_PARITY_EN defined, one even-parity bit per byte is stored and checked on every read.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic [DATA_W-1:0]   rdata
`ifdef MEM_PARITY_EN
  ,
  output logic                par_err
`endif
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^w[b*8 +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) par_mem[addr][b] <= ^wdata[b*8 +: 8];
      end
    end
  end

  // One-cycle flag, aligned with the word it refers to landing in rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= re && (byte_parity(mem[addr]) != par_mem[addr]);
    end
  end
`endif

endmodule

// File: rtl/burst_memory.sv
// burst_memory: single-port burst RAM on the CS_/RD_/WR_ tristate bus with byte enables,
// 1/2/4/8-beat bursts, Ready_ handshake and sticky Err. Parity is built in with MEM_PARITY_EN.
module burst_memory
  import burst_memory_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1 << ADDR_W,
  parameter int WRAP_BURST = 0
) (
  input  logic                Clk,
  input  logic                Rst_,
  input  logic [ADDR_W-1:0]   Addr,
  inout  wire  [DATA_W-1:0]   Data,
  input  logic [DATA_W/8-1:0] BE_,
  input  logic [1:0]          BLen,
  input  logic                CS_,
  input  logic                RD_,
  input  logic                WR_,
  output logic                Ready_,
  output logic                Err,
  output logic                ParErr
);

  localparam int NB = DATA_W / 8;

  state_t                 state;
  logic [ADDR_W-1:0]      addr_q;
  logic [1:0]             blen_q;
  logic [BURST_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]      nxt_addr;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_we;
  logic                   mem_re;
  logic [NB-1:0]          wbe;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_ok;
  logic                   wr_ok;
  logic                   drive;

  function automatic logic [BURST_CNT_W-1:0] beats_m1(input logic [1:0] bl);
    logic [3:0] b;
    b = blen_to_beats(bl) - 4'd1;
    return b[BURST_CNT_W-1:0];
  endfunction

  // Wrapping keeps the upper bits and cycles only the low log2(beats) bits.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        bl);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    mask = ADDR_W'(beats_m1(bl));
    inc  = a + ADDR_W'(1);
    if (WRAP_BURST != 0)                return (a & ~mask) | (inc & mask);
    else if (a == ADDR_W'(DEPTH - 1))   return '0;
    else                                return inc;
  endfunction

  assign rd_ok    = !CS_ && !RD_ && WR_;
  assign wr_ok    = !CS_ && !WR_ && RD_;
  assign nxt_addr = next_addr(addr_q, blen_q);
  assign wbe      = ~BE_;

  // Only drive while the read is still qualified, so an abort releases the bus at once.
  assign drive = (state == RBURST) && rd_ok;
  assign Data  = drive ? rd_data : {DATA_W{1'bz}};

  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = Addr;
    case (state)
      IDLE: begin
        mem_addr = Addr;
        mem_we   = wr_ok && Rst_;
        mem_re   = rd_ok && Rst_;
      end
      RBURST: begin
        mem_addr = nxt_addr;
        mem_re   = rd_ok && (cnt != '0);
      end
      WBURST: begin
        mem_addr = addr_q;
        mem_we   = wr_ok;
      end
      default: begin
        mem_addr = Addr;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      state  <= IDLE;
      Ready_ <= 1'b1;
      Err    <= 1'b0;
      addr_q <= '0;
      blen_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!CS_ && !RD_ && !WR_) begin
            Err <= 1'b1;
          end else if (rd_ok) begin
            addr_q <= Addr;
            blen_q <= BLen;
            cnt    <= beats_m1(BLen);
            state  <= RBURST;
            Ready_ <= 1'b0;
          end else if (wr_ok && (BLen != 2'b00)) begin
            // First beat is written this edge; the burst continues from the next address.
            addr_q <= next_addr(Addr, BLen);
            blen_q <= BLen;
            cnt    <= beats_m1(BLen) - BURST_CNT_W'(1);
            state  <= WBURST;
            Ready_ <= 1'b0;
          end
        end
        RBURST: begin
          if (!rd_ok || (cnt == '0)) begin
            if (!CS_ && !WR_) Err <= 1'b1;
            state  <= IDLE;
            Ready_ <= 1'b1;
          end else begin
            addr_q <= nxt_addr;
            cnt    <= cnt - BURST_CNT_W'(1);
          end
        end
        WBURST: begin
          if (!wr_ok || (cnt == '0)) begin
            if (!CS_ && !RD_) Err <= 1'b1;
            state  <= IDLE;
            Ready_ <= 1'b1;
          end else begin
            addr_q <= nxt_addr;
            cnt    <= cnt - BURST_CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          Ready_ <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  logic par_hit;

  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      ParErr <= 1'b0;
    end else if (par_hit) begin
      ParErr <= 1'b1;
    end
  end
`else
  assign ParErr = 1'b0;
`endif

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (Clk),
    .rst_n  (Rst_),
    .we     (mem_we),
    .re     (mem_re),
    .addr   (mem_addr),
    .wdata  (Data),
    .wbe    (wbe),
    .rdata  (rd_data)
`ifdef MEM_PARITY_EN
    ,
    .par_err(par_hit)
`endif
  );

endmodule
